// File: rtl/hs_pipe_slice.sv
// hs_pipe_slice: valid/ready pipeline slice (pass-through, forward, skid or two-entry) with a downstream transfer counter.
// Optional macro HS_PIPE_SLICE_DATA_GATE_EN forces data_post_o to zero whenever valid_post_o is low.
module hs_pipe_slice #(
    parameter int DATA_W = 8,
    parameter int MODE   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_pre_i,
    input  logic [DATA_W-1:0] data_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    output logic [DATA_W-1:0] data_post_o,
    input  logic              ready_post_i,
    output logic [CNT_W-1:0]  xfer_cnt_o
);
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [CNT_W-1:0]  r_cnt;

    generate
        if (MODE == 0) begin : g_pass
            assign ready_pre_o = ready_post_i;
            assign w_valid     = rst_n && valid_pre_i;
            assign w_data      = data_pre_i;
        end else if (MODE == 1) begin : g_fwd
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            assign ready_pre_o = !r_valid || ready_post_i;
            assign w_valid     = r_valid;
            assign w_data      = r_data;
            // Output register refills whenever it is empty or being drained this cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (ready_pre_o) begin
                    r_valid <= valid_pre_i;
                    if (valid_pre_i) r_data <= data_pre_i;
                end
            end
        end else if (MODE == 2) begin : g_skid
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            assign ready_pre_o = !r_skid_valid;
            assign w_valid     = rst_n && (valid_pre_i || r_skid_valid);
            assign w_data      = r_skid_valid ? r_skid_data : (data_pre_i & {DATA_W{rst_n}});
            // Skid captures an accepted word the downstream refused and empties on the next downstream transfer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                end else if (r_skid_valid) begin
                    if (ready_post_i) r_skid_valid <= 1'b0;
                end else if (valid_pre_i && !ready_post_i) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= data_pre_i;
                end
            end
        end else if (MODE == 3) begin : g_full
            logic              r_valid;
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_data;
            logic [DATA_W-1:0] r_skid_data;
            logic              w_up;
            logic              w_dn;
            assign ready_pre_o = !r_skid_valid;
            assign w_valid     = r_valid;
            assign w_data      = r_data;
            assign w_up        = valid_pre_i && !r_skid_valid;
            assign w_dn        = r_valid && ready_post_i;
            // Main holds the oldest word; skid only fills when main is held, and drains into main first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid      <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_data       <= '0;
                    r_skid_data  <= '0;
                end else if (r_skid_valid) begin
                    if (w_dn) begin
                        r_data       <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end
                end else if (!r_valid || w_dn) begin
                    r_valid <= w_up;
                    if (w_up) r_data <= data_pre_i;
                end else if (w_up) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= data_pre_i;
                end
            end
        end else begin : g_bad
            $error("hs_pipe_slice: MODE must be 0..3");
        end
    endgenerate

    assign valid_post_o = w_valid;
`ifdef HS_PIPE_SLICE_DATA_GATE_EN
    assign data_post_o = w_valid ? w_data : '0;
`else
    assign data_post_o = w_data;
`endif

    // Count completed downstream transfers, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (w_valid && ready_post_i) r_cnt <= r_cnt + 1'b1;
    end
    assign xfer_cnt_o = r_cnt;
endmodule
